// File: rtl/vector_list_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vector_list_ctrl_pkg
// Shared definitions for the double-buffered vector list controller:
//   - packed vector record layout {x0, y0, x1, y1, col}
//   - controller state encoding (IDLE / PEND / COPY)
// No ports (package).
// -----------------------------------------------------------------------------
package vector_list_ctrl_pkg;

    localparam int COORD_W   = 10;
    localparam int COL_W_DEF = 16;
    localparam int VEC_W     = 4 * COORD_W + COL_W_DEF;

    // Coordinate field offsets measured from the top of the color field,
    // so the record is {x0, y0, x1, y1, col} with col in the low bits.
    localparam int Y1_OFS = 0;
    localparam int X1_OFS = 1 * COORD_W;
    localparam int Y0_OFS = 2 * COORD_W;
    localparam int X0_OFS = 3 * COORD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_COPY = 2'd2
    } vl_state_t;

endpackage

// File: rtl/vector_list_ctrl_ram.sv
// -----------------------------------------------------------------------------
// vector_ram
// Simple dual-port synchronous RAM: port A is read-only with a registered
// read (data valid the cycle after a_en), port B is write-only.
// Ports:
//   clk                 clock
//   a_en, a_addr        port A read enable / address
//   a_rdata             port A read data (holds when a_en=0)
//   b_we, b_addr        port B write enable / address
//   b_wdata             port B write data
// -----------------------------------------------------------------------------
module vector_ram #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 56
) (
    input  logic              clk,
    input  logic              a_en,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata <= mem[a_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/vector_list_ctrl.sv
// -----------------------------------------------------------------------------
// vector_list_ctrl
// Double-buffered vector list for the scanline line engine. The CPU fills the
// back bank while the engine reads the front bank; banks swap at a frame
// trigger after a CPU commit. Engine fetch data appears one cycle after
// read_vector and is held while read_vector is low.
//
// Optional feature: define VL_RETAIN_EN to copy the new front list into the
// new back bank after each swap (COPY state), so the CPU can edit
// incrementally. Without it the back bank keeps stale contents.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   trigger                          start-of-frame pulse
//   vector, read_vector              engine fetch index / enable
//   x0, y0, x1, y1, col              fetched vector fields
//   last_vector                      fetched index >= front-bank count
//   cpu_we, cpu_addr, cpu_wdata      CPU back-bank write
//   cpu_commit, cpu_count            request swap with list length
//   cpu_ready                        back bank writable
//   front_bank                       bank read by the engine
// -----------------------------------------------------------------------------
import vector_list_ctrl_pkg::*;

module vector_list_ctrl #(
    parameter int NV    = 1024,
    parameter int COL_W = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        trigger,
    input  logic [$clog2(NV)-1:0]       vector,
    input  logic                        read_vector,
    output logic [9:0]                  x0,
    output logic [9:0]                  y0,
    output logic [9:0]                  x1,
    output logic [9:0]                  y1,
    output logic [COL_W-1:0]            col,
    output logic                        last_vector,
    input  logic                        cpu_we,
    input  logic [$clog2(NV)-1:0]       cpu_addr,
    input  logic [4*COORD_W+COL_W-1:0]  cpu_wdata,
    input  logic                        cpu_commit,
    input  logic [$clog2(NV):0]         cpu_count,
    output logic                        cpu_ready,
    output logic                        front_bank
);

    localparam int AW = $clog2(NV);
    localparam int VW = 4 * COORD_W + COL_W;
    localparam logic [AW:0] NV_CNT = (AW+1)'(NV);

    vl_state_t         state;
    logic [AW:0]       front_count;
    logic [AW:0]       pend_count;

    logic              ram_a_en;
    logic [AW:0]       ram_a_addr;
    logic [VW-1:0]     ram_rdata;
    logic              ram_b_we;
    logic [AW:0]       ram_b_addr;
    logic [VW-1:0]     ram_b_wdata;

    logic              fetch_vld_p1;
    logic [AW-1:0]     vq;
    logic              fetch_last;
    logic [VW-1:0]     hold_vec;
    logic              hold_last;
    logic [VW-1:0]     out_vec;

    function automatic logic [AW:0] sat_count(input logic [AW:0] c);
        return (c > NV_CNT) ? NV_CNT : c;
    endfunction

`ifdef VL_RETAIN_EN
    logic [AW:0]       copy_idx;
    logic              copy_rd_p0;
    logic              copy_rd_p1;
    logic [AW-1:0]     copy_addr_p1;

    // Copy reads only use port A in cycles the engine leaves it idle.
    assign copy_rd_p0 = (state == ST_COPY) && !read_vector && (copy_idx < front_count);
`endif

    vector_ram #(
        .ADDR_W (AW + 1),
        .DATA_W (VW)
    ) u_ram (
        .clk     (clk),
        .a_en    (ram_a_en),
        .a_addr  (ram_a_addr),
        .a_rdata (ram_rdata),
        .b_we    (ram_b_we),
        .b_addr  (ram_b_addr),
        .b_wdata (ram_b_wdata)
    );

    // Port A: engine fetch has absolute priority over the retain copy.
    always_comb begin
        ram_a_en   = read_vector;
        ram_a_addr = {front_bank, vector};
`ifdef VL_RETAIN_EN
        if (copy_rd_p0) begin
            ram_a_en   = 1'b1;
            ram_a_addr = {front_bank, copy_idx[AW-1:0]};
        end
`endif
    end

    // Port B: always the back bank. CPU and copy writes never overlap since
    // cpu_ready is low throughout COPY.
    always_comb begin
        ram_b_we    = cpu_we && cpu_ready && !rst;
        ram_b_addr  = {~front_bank, cpu_addr};
        ram_b_wdata = cpu_wdata;
`ifdef VL_RETAIN_EN
        if (copy_rd_p1) begin
            ram_b_we    = !rst;
            ram_b_addr  = {~front_bank, copy_addr_p1};
            ram_b_wdata = ram_rdata;
        end
`endif
    end

    // Stage p0 -> p1: fetch request registered alongside the RAM read.
    always_ff @(posedge clk) begin
        if (read_vector) begin
            vq <= vector;
        end
    end

    assign fetch_last = ({1'b0, vq} >= front_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_vld_p1 <= 1'b0;
            hold_vec     <= '0;
            hold_last    <= 1'b1;
        end else begin
            fetch_vld_p1 <= read_vector;
            if (fetch_vld_p1) begin
                hold_vec  <= ram_rdata;
                hold_last <= fetch_last;
            end
        end
    end

    // Stage p1 output: live RAM data right after a fetch, otherwise the hold copy.
    assign out_vec     = fetch_vld_p1 ? ram_rdata : hold_vec;
    assign last_vector = fetch_vld_p1 ? fetch_last : hold_last;
    assign x0          = out_vec[COL_W+X0_OFS +: COORD_W];
    assign y0          = out_vec[COL_W+Y0_OFS +: COORD_W];
    assign x1          = out_vec[COL_W+X1_OFS +: COORD_W];
    assign y1          = out_vec[COL_W+Y1_OFS +: COORD_W];
    assign col         = out_vec[COL_W-1:0];

`ifdef VL_RETAIN_EN
    always_ff @(posedge clk) begin
        copy_addr_p1 <= copy_idx[AW-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            front_bank  <= 1'b0;
            front_count <= '0;
            pend_count  <= '0;
            cpu_ready   <= 1'b1;
`ifdef VL_RETAIN_EN
            copy_idx    <= '0;
            copy_rd_p1  <= 1'b0;
`endif
        end else begin
`ifdef VL_RETAIN_EN
            copy_rd_p1 <= copy_rd_p0;
`endif
            case (state)
                ST_IDLE: begin
                    // A same-cycle write lands through port B before the commit takes effect.
                    if (cpu_commit) begin
                        pend_count <= sat_count(cpu_count);
                        state      <= ST_PEND;
                        cpu_ready  <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (trigger) begin
                        front_bank  <= ~front_bank;
                        front_count <= pend_count;
`ifdef VL_RETAIN_EN
                        copy_idx    <= '0;
                        state       <= ST_COPY;
`else
                        state       <= ST_IDLE;
                        cpu_ready   <= 1'b1;
`endif
                    end
                end
                ST_COPY: begin
`ifdef VL_RETAIN_EN
                    // Exit on the edge that performs the final copy write.
                    if (copy_idx >= front_count) begin
                        state     <= ST_IDLE;
                        cpu_ready <= 1'b1;
                    end else if (copy_rd_p0) begin
                        copy_idx <= copy_idx + (AW+1)'(1);
                    end
`else
                    state     <= ST_IDLE;
                    cpu_ready <= 1'b1;
`endif
                end
                default: begin
                    state     <= ST_IDLE;
                    cpu_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_list_ctrl.sv
module tb_vector_list_ctrl;

    localparam int NV    = 1024;
    localparam int AW    = 10;
    localparam int COL_W = 16;
    localparam int VW    = 40 + COL_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              trigger;
    logic [AW-1:0]     vector;
    logic              read_vector;
    logic [9:0]        x0, y0, x1, y1;
    logic [COL_W-1:0]  col;
    logic              last_vector;
    logic              cpu_we;
    logic [AW-1:0]     cpu_addr;
    logic [VW-1:0]     cpu_wdata;
    logic              cpu_commit;
    logic [AW:0]       cpu_count;
    logic              cpu_ready;
    logic              front_bank;

    always #5 clk = ~clk;

    vector_list_ctrl #(.NV(NV), .COL_W(COL_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .vector      (vector),
        .read_vector (read_vector),
        .x0          (x0),
        .y0          (y0),
        .x1          (x1),
        .y1          (y1),
        .col         (col),
        .last_vector (last_vector),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_commit  (cpu_commit),
        .cpu_count   (cpu_count),
        .cpu_ready   (cpu_ready),
        .front_bank  (front_bank)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [VW-1:0] pack(input int a, input int b, input int c, input int d, input int k);
        return {10'(a), 10'(b), 10'(c), 10'(d), 16'(k)};
    endfunction

    // ---------------- behavioural reference model ----------------
    // Banks as plain arrays; the retain copy is applied instantly at the swap
    // (the engine only ever sees the front bank, so this is observably equal).
    logic [VW-1:0] mem   [2][NV];
    bit            known [2][NV];
    int            m_front, m_fcount, m_pcount, m_mode, m_copy_left; // mode: 0 open, 1 waiting, 2 copying
    logic [VW-1:0] exp_vec;
    bit            exp_known;
    bit            exp_last;
    bit            m_valid = 0;
    int            f_vec;

    always @(posedge clk) begin
        if (rst) begin
            if (m_valid && m_mode == 2)
                for (int i = 0; i < NV; i++) known[1-m_front][i] = 0;
            m_front = 0; m_fcount = 0; m_pcount = 0; m_mode = 0; m_copy_left = 0;
            exp_vec = '0; exp_known = 1; exp_last = 1;
            m_valid = 1;
        end else if (m_valid) begin
            if (read_vector) begin
                f_vec     = int'(vector);
                exp_vec   = mem[m_front][f_vec];
                exp_known = known[m_front][f_vec];
            end
            case (m_mode)
                0: begin
                    if (cpu_we) begin
                        mem[1-m_front][cpu_addr]   = cpu_wdata;
                        known[1-m_front][cpu_addr] = 1;
                    end
                    if (cpu_commit) begin
                        m_pcount = (int'(cpu_count) > NV) ? NV : int'(cpu_count);
                        m_mode   = 1;
                    end
                end
                1: begin
                    if (trigger) begin
                        m_front  = 1 - m_front;
                        m_fcount = m_pcount;
`ifdef VL_RETAIN_EN
                        for (int i = 0; i < m_fcount; i++) begin
                            mem[1-m_front][i]   = mem[m_front][i];
                            known[1-m_front][i] = known[m_front][i];
                        end
                        m_copy_left = m_fcount;
                        m_mode      = 2;
`else
                        m_mode = 0;
`endif
                    end
                end
                default: begin
                    // One idle port-A slot per entry, then one closing cycle.
                    if (m_copy_left == 0) m_mode = 0;
                    else if (!read_vector) m_copy_left--;
                end
            endcase
            if (read_vector) exp_last = (f_vec >= m_fcount);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("cpu_ready", 64'(cpu_ready), 64'(m_mode == 0));
            check("front_bank", 64'(front_bank), 64'(m_front));
            check("last_vector", 64'(last_vector), 64'(exp_last));
            if (exp_known)
                check("vec_data", 64'({x0, y0, x1, y1, col}), 64'(exp_vec));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        trigger = 0; read_vector = 0; cpu_we = 0; cpu_commit = 0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cpu_ready && n < 5000) begin
            step();
            n++;
        end
        total++;
        if (!cpu_ready) begin
            bad++;
            $display("FAIL wait_ready: cpu_ready stayed %0b want 1", cpu_ready);
        end
    endtask

    task automatic fetch(input int v);
        read_vector = 1; vector = AW'(v);
        step();
        read_vector = 0;
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [VW-1:0] d);
        cpu_we = 1; cpu_addr = AW'(a); cpu_wdata = d;
        step();
        cpu_we = 0;
    endtask

    task automatic commit_trig(input int cnt);
        cpu_commit = 1; cpu_count = (AW+1)'(cnt);
        step();
        cpu_commit = 0;
        trigger = 1;
        step();
        trigger = 0;
    endtask

    initial begin
        rst = 1; vector = '0; cpu_addr = '0; cpu_wdata = '0; cpu_count = '0;
        clr();
        step(); step();
        rst = 0;

        // Reset state and empty list
        fetch(0);
        check("rst_last", 64'(last_vector), 64'd1);
        check("rst_ready", 64'(cpu_ready), 64'd1);
        check("rst_bank", 64'(front_bank), 64'd0);

        // Fill two entries, swap, read back
        wr(0, pack(10, 20, 30, 40, 'hF800));
        wr(1, pack(1, 2, 3, 4, 'h1234));
        commit_trig(2);
        wait_ready();
        fetch(0);
        check("v0_x0", 64'(x0), 64'd10);
        check("v0_y0", 64'(y0), 64'd20);
        check("v0_x1", 64'(x1), 64'd30);
        check("v0_y1", 64'(y1), 64'd40);
        check("v0_col", 64'(col), 64'hF800);
        check("v0_last", 64'(last_vector), 64'd0);
        check("swap_bank", 64'(front_bank), 64'd1);
        fetch(1);
        check("v1_col", 64'(col), 64'h1234);
        check("v1_last", 64'(last_vector), 64'd0);
        fetch(2);
        check("v2_last", 64'(last_vector), 64'd1);

        // Hold while the CPU writes the back bank
        fetch(0);
        for (int i = 0; i < 5; i++) begin
            wr(i, pack(100 + i, 200 + i, 300 + i, 400 + i, 'hA000 + i));
            @(negedge clk);
            check("hold_x0", 64'(x0), 64'd10);
            check("hold_col", 64'(col), 64'hF800);
        end

        // Write after commit is dropped; second commit ignored
        cpu_commit = 1; cpu_count = 1;
        step();
        cpu_commit = 0;
        wr(0, pack(9, 9, 9, 9, 'h9999));
        @(negedge clk);
        check("pend_ready", 64'(cpu_ready), 64'd0);
        commit_trig(5);
        wait_ready();
        fetch(1);
        check("cnt1_last1", 64'(last_vector), 64'd1);
        fetch(0);
        check("cnt1_last0", 64'(last_vector), 64'd0);
        check("drop_x0", 64'(x0), 64'd100);

`ifdef VL_RETAIN_EN
        // Copy with engine reading every other cycle
        cpu_commit = 1; cpu_count = 3;
        step();
        cpu_commit = 0; trigger = 1;
        step();
        trigger = 0;
        for (int n = 0; n < 100 && !cpu_ready; n++) begin
            read_vector = (n % 2 == 0); vector = AW'(n % 3);
            step();
        end
        read_vector = 0;
        check("copy_done", 64'(cpu_ready), 64'd1);
        commit_trig(3);
        wait_ready();
        for (int i = 0; i < 3; i++) fetch(i);
`endif

        // Count saturation
        wr(1023, pack(7, 7, 7, 7, 'h0707));
        commit_trig(2000);
        wait_ready();
        fetch(1023);
        check("sat_last", 64'(last_vector), 64'd0);

        // Reset in the middle of a long copy (or of idle without the copy)
        cpu_commit = 1; cpu_count = 11'd2000;
        step();
        cpu_commit = 0; trigger = 1;
        step();
        trigger = 0;
        step(); step();
        rst = 1;
        step();
        rst = 0;
        @(negedge clk);
        check("rst_mid_ready", 64'(cpu_ready), 64'd1);
        check("rst_mid_bank", 64'(front_bank), 64'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            read_vector = 1'($urandom_range(0, 1));
            vector      = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NV-1)) : AW'($urandom_range(0, 7));
            cpu_we      = 1'($urandom_range(0, 1));
            cpu_addr    = AW'($urandom_range(0, 7));
            cpu_wdata   = VW'({$urandom, $urandom});
            cpu_commit  = ($urandom_range(0, 15) == 0);
            cpu_count   = ($urandom_range(0, 49) == 0) ? 11'd2000 : (AW+1)'($urandom_range(0, 10));
            trigger     = ($urandom_range(0, 7) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 0;
        clr();
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
